// File: rtl/l1_trigger_fifo_pkg.sv
// Shared definitions for the L1 trigger FIFO: default sizes, entry layout and
// the 2-of-3 majority vote used by the hardened control registers.
package l1_trigger_fifo_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_BCID_W = 8;
  localparam int DEF_L1ID_W = 5;

  // Widest vector the voter handles; narrower callers zero-extend and truncate.
  localparam int VOTE_W = 32;

  // Entry layout, MSB first: {SkipFlag, L1ID, BCID}.
  function automatic int entry_w(input int bcid_w, input int l1id_w);
    return bcid_w + l1id_w + 1;
  endfunction

  function automatic logic [VOTE_W-1:0] maj3(input logic [VOTE_W-1:0] a,
                                             input logic [VOTE_W-1:0] b,
                                             input logic [VOTE_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/l1_trigger_fifo_tmr.sv
// Triplicated register: three copies reloaded every cycle from d_i, output is
// the bitwise majority, so a single upset copy heals on the next edge.
module tmr_reg
  import l1_trigger_fifo_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] c0_q, c1_q, c2_q;

  assign q_o = W'(maj3(VOTE_W'(c0_q), VOTE_W'(c1_q), VOTE_W'(c2_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
    end else begin
      c0_q <= d_i;
      c1_q <= d_i;
      c2_q <= d_i;
    end
  end

endmodule

// File: rtl/l1_trigger_fifo.sv
// L1 trigger acceptance FIFO: timestamps each trigger with BCID/L1ID, flags
// entries that follow dropped triggers and pulses ReadSkipped when one is popped.
module l1_trigger_fifo
  import l1_trigger_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BCID_W = DEF_BCID_W,
  parameter int L1ID_W = DEF_L1ID_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     L1,
  input  logic                     BCR,
  input  logic                     ECR,
  input  logic                     ReadL1,
  output logic                     L1_Reg_Full,
  output logic                     L1_Empty,
  output logic [BCID_W-1:0]        BCID_Out,
  output logic [L1ID_W-1:0]        L1ID_Out,
  output logic                     SkipFlag_Out,
  output logic                     ReadSkipped,
  output logic [$clog2(DEPTH):0]   Occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int EW = entry_w(BCID_W, L1ID_W);

  logic [BCID_W-1:0] bcid_q, bcid_now;
  logic [L1ID_W-1:0] l1id_q, l1id_now;
  logic [AW-1:0]     wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [OW-1:0]     occ, occ_d;
  logic              skip_pend, skip_pend_d;
  logic              full, empty, push, pop, drop;
  logic              rd_skip_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     head;

  // BCR/ECR act on the value used in their own cycle, so a coincident trigger sees 0.
  assign bcid_now = BCR ? '0 : bcid_q;
  assign l1id_now = ECR ? '0 : l1id_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bcid_q <= '0;
      l1id_q <= '0;
    end else begin
      bcid_q <= bcid_now + BCID_W'(1);
      if (L1)       l1id_q <= l1id_now + L1ID_W'(1);
      else if (ECR) l1id_q <= '0;
    end
  end

  // Full comes from registered occupancy, so a same-cycle pop never rescues a trigger.
  assign full  = (occ == OW'(DEPTH));
  assign empty = (occ == '0);
  assign push  = L1 & ~full;
  assign drop  = L1 & full;
  assign pop   = ReadL1 & ~empty;

  assign wr_ptr_d = wr_ptr + AW'(push);
  assign rd_ptr_d = rd_ptr + AW'(pop);

  always_comb begin
    occ_d = occ;
    if (push & ~pop)      occ_d = occ + OW'(1);
    else if (pop & ~push) occ_d = occ - OW'(1);
  end

  always_comb begin
    skip_pend_d = skip_pend;
    if (push)      skip_pend_d = 1'b0;
    else if (drop) skip_pend_d = 1'b1;
  end

  tmr_reg #(.W(AW)) u_wr_ptr (.clk(Clk), .rst_n(Reset), .d_i(wr_ptr_d),    .q_o(wr_ptr));
  tmr_reg #(.W(AW)) u_rd_ptr (.clk(Clk), .rst_n(Reset), .d_i(rd_ptr_d),    .q_o(rd_ptr));
  tmr_reg #(.W(OW)) u_occ    (.clk(Clk), .rst_n(Reset), .d_i(occ_d),       .q_o(occ));
  tmr_reg #(.W(1))  u_skip   (.clk(Clk), .rst_n(Reset), .d_i(skip_pend_d), .q_o(skip_pend));

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr] <= {skip_pend, l1id_now, bcid_now};
  end

  assign head = mem_q[rd_ptr];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rd_skip_q <= 1'b0;
    else        rd_skip_q <= pop & head[EW-1];
  end

  // Head is masked while empty so stale or uninitialised storage never shows.
  assign BCID_Out     = empty ? '0 : head[BCID_W-1:0];
  assign L1ID_Out     = empty ? '0 : head[BCID_W +: L1ID_W];
  assign SkipFlag_Out = empty ? 1'b0 : head[EW-1];
  assign L1_Reg_Full  = full;
  assign L1_Empty     = empty;
  assign Occupancy    = occ;
  assign ReadSkipped  = rd_skip_q;

endmodule

// File: tb/tb_l1_trigger_fifo.sv
// Directed bench for l1_trigger_fifo: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_l1_trigger_fifo;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       L1 = 1'b0, BCR = 1'b0, ECR = 1'b0, ReadL1 = 1'b0;
  logic       L1_Reg_Full, L1_Empty, SkipFlag_Out, ReadSkipped;
  logic [7:0] BCID_Out;
  logic [4:0] L1ID_Out;
  logic [4:0] Occupancy;

  int n_checks = 0;
  int n_err    = 0;

  l1_trigger_fifo #(.DEPTH(16), .BCID_W(8), .L1ID_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .L1(L1), .BCR(BCR), .ECR(ECR), .ReadL1(ReadL1),
    .L1_Reg_Full(L1_Reg_Full), .L1_Empty(L1_Empty), .BCID_Out(BCID_Out),
    .L1ID_Out(L1ID_Out), .SkipFlag_Out(SkipFlag_Out), .ReadSkipped(ReadSkipped),
    .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic l1, input logic rd, input logic bcr, input logic ecr);
    L1 = l1; ReadL1 = rd; BCR = bcr; ECR = ecr;
    @(posedge Clk);
    #1;
    L1 = 1'b0; ReadL1 = 1'b0; BCR = 1'b0; ECR = 1'b0;
  endtask

  // Called 1 unit after a posedge; releases before the next edge so BCID restarts at 0.
  task automatic do_reset(input string tag);
    Reset = 1'b0;
    #2;
    chk({tag, "_empty"}, L1_Empty, 1);
    chk({tag, "_full"},  L1_Reg_Full, 0);
    chk({tag, "_occ"},   Occupancy, 0);
    chk({tag, "_bcid"},  BCID_Out, 0);
    chk({tag, "_rdsk"},  ReadSkipped, 0);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    @(posedge Clk);
    #1;
    do_reset("rst0");

    // 1: single trigger at BCID 5, then pop
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t1_empty", L1_Empty, 0);
    chk("t1_bcid",  BCID_Out, 5);
    chk("t1_l1id",  L1ID_Out, 0);
    chk("t1_skip",  SkipFlag_Out, 0);
    chk("t1_occ",   Occupancy, 1);
    step(0, 1, 0, 0);
    chk("t1_pop_empty", L1_Empty, 1);
    chk("t1_pop_rdsk",  ReadSkipped, 0);
    step(0, 0, 0, 0);
    chk("t1_rdsk_idle", ReadSkipped, 0);

    // 2: fill, drop three, pop one, push one carrying the skip flag
    do_reset("rst2");
    repeat (16) step(1, 0, 0, 0);
    chk("t2_full", L1_Reg_Full, 1);
    chk("t2_occ",  Occupancy, 16);
    chk("t2_head", L1ID_Out, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("t2_drop_occ", Occupancy, 16);
    step(0, 1, 0, 0);
    chk("t2_pop_occ",  Occupancy, 15);
    chk("t2_pop_full", L1_Reg_Full, 0);
    chk("t2_pop_head", L1ID_Out, 1);
    chk("t2_pop_bcid", BCID_Out, 1);
    chk("t2_pop_rdsk", ReadSkipped, 0);
    step(1, 0, 0, 0);
    chk("t2_push_occ", Occupancy, 16);
    repeat (15) step(0, 1, 0, 0);
    chk("t2_tail_l1id", L1ID_Out, 19);
    chk("t2_tail_skip", SkipFlag_Out, 1);
    chk("t2_tail_rdsk", ReadSkipped, 0);
    step(0, 1, 0, 0);
    chk("t2_rdsk_pulse", ReadSkipped, 1);
    chk("t2_last_empty", L1_Empty, 1);
    step(0, 0, 0, 0);
    chk("t2_rdsk_end", ReadSkipped, 0);

    // 3: full FIFO, trigger and pop together -> trigger dropped
    do_reset("rst3");
    repeat (16) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("t3_occ",  Occupancy, 15);
    chk("t3_head", L1ID_Out, 1);
    step(1, 0, 0, 0);
    chk("t3_push_occ", Occupancy, 16);
    repeat (15) step(0, 1, 0, 0);
    chk("t3_tail_l1id", L1ID_Out, 17);
    chk("t3_tail_skip", SkipFlag_Out, 1);

    // 4: ECR with L1, BCR timing, L1ID wrap
    do_reset("rst4");
    repeat (7) step(1, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0);
    chk("t4_drained", L1_Empty, 1);
    step(1, 0, 0, 1);
    chk("t4_ecr_l1id", L1ID_Out, 0);
    step(1, 1, 0, 0);
    chk("t4_after_ecr", L1ID_Out, 1);
    chk("t4_occ1", Occupancy, 1);
    step(0, 1, 1, 0);
    chk("t4_bcr_empty", L1_Empty, 1);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t4_bcr_bcid", BCID_Out, 3);
    chk("t4_bcr_l1id", L1ID_Out, 2);
    step(1, 1, 1, 0);
    chk("t4_bcr_l1_bcid", BCID_Out, 0);
    chk("t4_bcr_l1_l1id", L1ID_Out, 3);
    repeat (28) step(1, 1, 0, 0);
    chk("t4_l1id_31", L1ID_Out, 31);
    step(1, 1, 0, 0);
    chk("t4_wrap", L1ID_Out, 0);
    chk("t4_wrap_occ", Occupancy, 1);

    // 5: upset one write-pointer copy, then pop on empty
    do_reset("rst5");
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    force dut.u_wr_ptr.c0_q = 4'hA;
    #1;
    release dut.u_wr_ptr.c0_q;
    step(1, 0, 0, 0);
    chk("t5_heal", dut.u_wr_ptr.c0_q, 3);
    chk("t5_occ", Occupancy, 3);
    step(0, 1, 0, 0);
    chk("t5_pop0", L1ID_Out, 1);
    step(0, 1, 0, 0);
    chk("t5_pop1", L1ID_Out, 2);
    step(0, 1, 0, 0);
    chk("t5_empty", L1_Empty, 1);
    step(0, 1, 0, 0);
    chk("t5_rd_empty_occ",  Occupancy, 0);
    chk("t5_rd_empty_flag", L1_Empty, 1);
    chk("t5_rd_empty_rdsk", ReadSkipped, 0);
    step(1, 0, 0, 0);
    chk("t5_next_l1id", L1ID_Out, 3);
    chk("t5_next_occ",  Occupancy, 1);

    // 6: reset with entries held and a skip pending
    do_reset("rst6");
    repeat (16) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (11) step(0, 1, 0, 0);
    chk("t6_pre_occ", Occupancy, 5);
    do_reset("t6_rst");
    step(1, 0, 0, 0);
    chk("t6_skip", SkipFlag_Out, 0);
    chk("t6_l1id", L1ID_Out, 0);
    chk("t6_bcid", BCID_Out, 0);
    chk("t6_occ",  Occupancy, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/l1_trigger_fifo.md
Name: l1_trigger_fifo

Overview:
Trigger-acceptance stage directly upstream of the skipped-trigger counter. Captures each L1 trigger with its BCID timestamp and L1ID into a small FIFO for the read-out controller. Drives L1_Reg_Full, which the skipped counter uses to count dropped triggers. Pulses ReadSkipped when an entry that follows a dropped-trigger burst is popped, so the skipped count is read and cleared alongside that event.

Parameters:
DEPTH, 16, trigger FIFO entries (power of 2, >= 2)
BCID_W, 8, BCID timestamp width
L1ID_W, 5, trigger ID width

Ports:
Clk  in  1  system clock (40 MHz BC clock)
Reset  in  1  asynchronous active-low reset
L1  in  1  trigger strobe, one cycle per trigger
BCR  in  1  bunch-counter reset strobe
ECR  in  1  event-counter reset strobe
ReadL1  in  1  pop strobe from read-out controller
L1_Reg_Full  out  1  FIFO full; a trigger arriving now is dropped
L1_Empty  out  1  FIFO empty
BCID_Out  out  BCID_W  head-entry BCID
L1ID_Out  out  L1ID_W  head-entry L1ID
SkipFlag_Out  out  1  head entry follows one or more dropped triggers
ReadSkipped  out  1  one-cycle pulse: skipped count belongs to the popped event
Occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, Reset=0): all counters, pointers, skip_pending and ReadSkipped = 0. L1_Empty = 1, L1_Reg_Full = 0, Occupancy = 0. Head outputs = 0.
- BCID counter: free-running, +1 per Clk, wraps at 2^BCID_W-1 -> 0. BCR loads 0; the counter is 1 on the next cycle.
- L1ID counter: +1 on every L1, accepted or dropped, wrapping modulo 2^L1ID_W.
  - ECR clears it to 0.
  - ECR and L1 in the same cycle: the trigger is stored with L1ID=0 and the counter becomes 1.
- Push:
  - L1=1 and Occupancy<DEPTH: write {BCID, L1ID, skip_pending} at the write pointer and clear skip_pending.
  - The stored BCID/L1ID are the counter values in the L1 cycle, before any increment.
- Drop:
  - L1=1 and L1_Reg_Full=1: nothing written; set skip_pending.
  - L1_Reg_Full is registered, equal to (Occupancy==DEPTH). A same-cycle pop does not rescue the trigger, so drop accounting matches the skipped counter exactly.
- Pop:
  - ReadL1=1 and !L1_Empty: advance the read pointer.
  - ReadL1 while empty: ignored, no state change.
- Simultaneous push and pop (non-empty, not full): Occupancy unchanged, both pointers advance.
- Head data (BCID_Out, L1ID_Out, SkipFlag_Out):
  - Show-ahead from the head entry, valid whenever L1_Empty=0.
  - A push into an empty FIFO in cycle n is visible, with L1_Empty=0, in cycle n+1.
- ReadSkipped:
  - Registered pulse in the cycle after a pop whose head had SkipFlag_Out=1.
  - Exactly one cycle long.
- Occupancy, L1_Empty and L1_Reg_Full update one cycle after the causing push/pop.
- SEU hardening:
  - Write pointer, read pointer, occupancy and skip_pending are each held in three copies.
  - All copies are reloaded every cycle from the 2-of-3 majority vote, so a single upset self-heals in one cycle.
  - The FIFO data memory is not triplicated.
- A reset mid-operation discards all entries and any pending skip.

Decomposition:
- Shared package: entry field widths and packing order {SkipFlag, L1ID, BCID}, plus a majority-vote function usable on any vector width.
- Sub-module tmr_reg (width parameter, 3 copies, voted output, async active-low reset). Instantiate it for the pointers, occupancy and skip_pending.
- FIFO storage: register array in the top module.

Test Plan:
1. Reset then a single L1 at BCID=5 -> next cycle L1_Empty=0, BCID_Out=5, L1ID_Out=0, SkipFlag_Out=0; after ReadL1, L1_Empty=1 and ReadSkipped stays 0.
2. 16 L1s without pops -> L1_Reg_Full=1, Occupancy=16. Then 3 more L1s -> dropped, L1ID counter=19. Then pop one and push one L1 -> new entry has L1ID=19, SkipFlag=1. Popping that entry yields ReadSkipped=1 for exactly one cycle.
3. Full FIFO with L1 and ReadL1 in the same cycle -> trigger dropped, Occupancy=15, skip_pending set.
4. ECR coincident with L1 while the counter is 7 -> entry L1ID=0, next L1 gets ID 1. BCR -> BCID_Out of the next trigger reflects the count since BCR. L1ID wraps 31->0.
5. Force-flip one copy of the write pointer -> stored and popped data unaffected, copy restored the next cycle. ReadL1 on an empty FIFO -> no change.
6. Assert Reset with 5 entries held and skip_pending set -> immediately L1_Empty=1, Occupancy=0. The first post-reset entry has SkipFlag=0.
